// File: rtl/contador_dec_regressivo.sv
// rtl/contador_dec_regressivo.sv - multi-digit BCD down-counter with terminal count and auto-reload
module contador_dec_regressivo #(
  parameter int DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  input  logic                  EN,
  input  logic                  MODE,
  output logic [4*DIGITS-1:0]   CNT,
  output logic                  ZERO,
  output logic                  TC,
  output logic                  ERR
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           tc_q, tc_d;
  logic           err_q, err_d;

  logic [W-1:0]   cnt_dec;
  logic           load_ok;
  logic           borrow;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (LOAD_VAL[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Borrow enters digit 0 and ripples upward; a digit at 0 wraps to 9 and passes it on.
  always_comb begin
    cnt_dec = cnt_q;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (cnt_q[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    err_d    = err_q;

    if (LOAD) begin
      if (load_ok) begin
        cnt_d    = LOAD_VAL;
        reload_d = LOAD_VAL;
        err_d    = 1'b0;
        state_d  = (LOAD_VAL != '0) ? RUN : DONE;
      end else begin
        err_d    = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        RUN: begin
          if (EN) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_dec;
              if (cnt_dec == '0) begin
                tc_d = 1'b1;
                if (!MODE) begin
                  state_d = DONE;
                end
              end
            end else if (MODE) begin
              cnt_d = reload_q;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
    end
  end

  assign CNT  = cnt_q;
  assign ZERO = (cnt_q == '0);
  assign TC   = tc_q;
  assign ERR  = err_q;

endmodule

// File: doc/contador_dec_regressivo.md
Name: contador_dec_regressivo

Overview:
- Multi-digit BCD down-counter (timer), the decrementing counterpart of the team's decimal up-counter.
- Loads a BCD start value and counts down once per enabled clock.
- Signals terminal count, and either stops at zero or auto-reloads.
- Feeds countdown displays and interval timers; cascades digit borrows internally.

Parameters:
- DIGITS, 2, number of BCD digits; count width is 4*DIGITS bits.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST_N  input  1  reset, asynchronous, active-low.
- LOAD  input  1  load LOAD_VAL on next rising edge; priority over EN.
- LOAD_VAL  input  4*DIGITS  BCD start/reload value; digit 0 in bits [3:0].
- EN  input  1  count enable; one decrement per enabled edge.
- MODE  input  1  0 = stop at zero; 1 = auto-reload at zero.
- CNT  output  4*DIGITS  current BCD count (registered).
- ZERO  output  1  combinational, high when CNT == 0.
- TC  output  1  registered terminal-count pulse, one cycle wide.
- ERR  output  1  sticky flag: last load attempt contained a non-BCD digit.

Behaviour:
- One clock: CLK. Reset is asynchronous and active-low on RST_N. Reset acts immediately, independent of CLK.
- Reset values: CNT=0, reload register=0, TC=0, ERR=0, state=IDLE; hence ZERO=1.
- States: IDLE, RUN, DONE.
  - IDLE: EN ignored.
  - LOAD is accepted in every state.
- LOAD=1 with all digits of LOAD_VAL in 0..9:
  - Next edge: CNT<=LOAD_VAL, reload<=LOAD_VAL, ERR<=0, TC<=0.
  - State -> RUN if LOAD_VAL != 0, else DONE.
- LOAD=1 with any digit > 9:
  - Load is ignored; CNT, reload and state are unchanged.
  - ERR<=1, held until the next valid load or reset.
- RUN, EN=1, CNT != 0: BCD decrement.
  - Digit 0 decrements by 1. A digit at 0 wraps to 9 and borrows from the next digit.
  - Borrow ripples across all DIGITS within one cycle; no binary values ever appear.
- RUN, EN=1, transition to zero: on the edge where CNT becomes 0, TC<=1 for exactly that one cycle.
  - MODE=0: state -> DONE; CNT holds 0.
  - MODE=1: state stays RUN. The next enabled edge at CNT==0 loads CNT<=reload, with no TC.
  - Period in MODE=1 is therefore reload+1 enabled cycles.
- RUN, EN=1, CNT==0 (e.g. MODE changed to 1 after reaching zero):
  - MODE=1: reload as above.
  - MODE=0: state -> DONE, no TC.
- RUN, EN=0: CNT and state hold. TC returns to 0 after its single cycle.
- DONE: CNT=0, EN ignored, TC=0. Only LOAD or reset leaves DONE.
- MODE is sampled every cycle; a change takes effect on the next zero decision.
- LOAD and EN both high: load wins, no decrement that cycle.
- Reset mid-count: CNT=0 and state=IDLE immediately; a pending TC is cleared.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with random inputs -> CNT=0x00, ZERO=1, TC=0, ERR=0; release -> outputs stay at those values while LOAD=0.
- MODE=0, load 0x12, EN=1:
  - CNT steps 0x11, 0x10, 0x09 ... 0x01, 0x00.
  - TC=1 only on the cycle CNT first reads 0x00.
  - CNT stays 0x00 for 5 more cycles with EN=1.
- Borrow and zero load:
  - Load 0x10, one enabled edge -> CNT=0x09.
  - Load 0x00 -> state DONE, ZERO=1, TC never asserts.
- MODE=1, load 0x03, EN=1:
  - Sequence 03, 02, 01, 00 (TC=1), 03, 02, 01, 00 (TC=1).
  - TC spacing is exactly 4 cycles.
- Invalid load:
  - With CNT=0x07, load 0x1A -> ERR=1, CNT=0x07 unchanged, counting continues.
  - Then load 0x05 -> ERR=0, CNT=0x05.
- EN gating and async reset:
  - Load 0x50 and toggle EN every other cycle -> one decrement per EN=1 edge only.
  - Drop RST_N between edges at CNT=0x47 -> CNT=0x00 before the next CLK edge.
